// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/forwarding unit: operand-select encoding
// and default register-file geometry.
package hazard_pkg;

  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_REG_AW   = 5;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10,
    FWD_LT   = 2'b11
  } fwd_sel_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register scoreboard for long-latency ops: pending bits, watchdog
// countdowns and the sticky timeout flag.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int REG_AW   = DEF_REG_AW,
  parameter int LAT_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_AW-1:0]   ex_rd,
  input  logic                ex_reg_write,
  input  logic                ex_long_issue,
  input  logic [LAT_W-1:0]    ex_long_lat,
  input  logic                lt_done,
  input  logic [REG_AW-1:0]   lt_rd,
  output logic [NUM_REGS-1:0] sb_busy,
  output logic                sb_timeout
);

  logic [NUM_REGS-1:0] pending_q;
  logic [LAT_W-1:0]    cnt_q [NUM_REGS];
  logic                set_valid;
  logic [LAT_W-1:0]    set_cnt;
  logic                expired;

  assign set_valid = ex_long_issue && ex_reg_write && (ex_rd != '0);
  // A zero budget would expire immediately; treat it as one cycle.
  assign set_cnt   = (ex_long_lat == '0) ? LAT_W'(1) : ex_long_lat;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    expired = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (pending_q[r] && (cnt_q[r] == '0) && !(lt_done && (lt_rd == REG_AW'(r))))
        expired = 1'b1;
    end
  end

  // NOTE: the countdown array is reset explicitly because a stale count left
  // behind a cleared pending bit would be reloaded before it is ever read anyway,
  // but resetting it keeps the state fully deterministic out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= '0;
      sb_timeout <= 1'b0;
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
    end else begin
      if (expired) sb_timeout <= 1'b1;
      for (int r = 0; r < NUM_REGS; r++) begin
        // A new issue to the same register supersedes a completing older op.
        if (set_valid && (ex_rd == REG_AW'(r))) begin
          pending_q[r] <= 1'b1;
          cnt_q[r]     <= set_cnt;
        end else if (lt_done && (lt_rd == REG_AW'(r))) begin
          pending_q[r] <= 1'b0;
          cnt_q[r]     <= '0;
        end else if (pending_q[r] && (cnt_q[r] != '0)) begin
          cnt_q[r]     <= cnt_q[r] - LAT_W'(1);
        end
      end
    end
  end

  assign sb_busy = pending_q;

endmodule

// File: rtl/hazard_forward_unit.sv
// Forwarding, load-use/long-op stall generation, registered long-result
// bypass and stall-cycle counter for the 5-stage integer pipeline.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int REG_AW   = DEF_REG_AW,
  parameter int LAT_W    = 4,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_AW-1:0]   id_rs1,
  input  logic [REG_AW-1:0]   id_rs2,
  input  logic                id_use_rs1,
  input  logic                id_use_rs2,
  input  logic [REG_AW-1:0]   id_rd,
  input  logic                id_reg_write,
  input  logic [REG_AW-1:0]   ex_rs1,
  input  logic [REG_AW-1:0]   ex_rs2,
  input  logic [REG_AW-1:0]   ex_rd,
  input  logic                ex_reg_write,
  input  logic                ex_mem_read,
  input  logic                ex_long_issue,
  input  logic [LAT_W-1:0]    ex_long_lat,
  input  logic [REG_AW-1:0]   mem_rd,
  input  logic                mem_reg_write,
  input  logic [REG_AW-1:0]   wb_rd,
  input  logic                wb_reg_write,
  input  logic                lt_done,
  input  logic [REG_AW-1:0]   lt_rd,
  input  logic                flush,
  output logic [1:0]          forward_a,
  output logic [1:0]          forward_b,
  output logic                stall_id,
  output logic [NUM_REGS-1:0] sb_busy,
  output logic                sb_timeout,
  output logic [CNT_W-1:0]    stall_count
);

  logic              lt_q_valid;
  logic [REG_AW-1:0] lt_q_rd;
  logic              load_use, raw, waw;

  hazard_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .REG_AW   (REG_AW),
    .LAT_W    (LAT_W)
  ) u_scoreboard (
    .clk           (clk),
    .rst           (rst),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .ex_long_issue (ex_long_issue),
    .ex_long_lat   (ex_long_lat),
    .lt_done       (lt_done),
    .lt_rd         (lt_rd),
    .sb_busy       (sb_busy),
    .sb_timeout    (sb_timeout)
  );

  function automatic fwd_sel_t pick_fwd(
    input logic [REG_AW-1:0] src,
    input logic [REG_AW-1:0] m_rd,  input logic m_wr,
    input logic [REG_AW-1:0] l_rd,  input logic l_vld,
    input logic [REG_AW-1:0] w_rd,  input logic w_wr
  );
    if (src == '0)                   return FWD_NONE;
    else if (m_wr  && (m_rd == src)) return FWD_MEM;
    else if (l_vld && (l_rd == src)) return FWD_LT;
    else if (w_wr  && (w_rd == src)) return FWD_WB;
    else                             return FWD_NONE;
  endfunction

  // A register blocks ID while pending, except in the cycle its result
  // arrives: the consumer then reaches EX just as lt_q holds the value.
  function automatic logic blocked(
    input logic [REG_AW-1:0]   src,
    input logic [NUM_REGS-1:0] busy,
    input logic                done,
    input logic [REG_AW-1:0]   done_rd
  );
    return (src != '0) && busy[src] && !(done && (done_rd == src));
  endfunction

  always_comb begin
    forward_a = FWD_NONE;
    forward_b = FWD_NONE;
    if (!rst) begin
      forward_a = pick_fwd(ex_rs1, mem_rd, mem_reg_write, lt_q_rd, lt_q_valid,
                           wb_rd, wb_reg_write);
      forward_b = pick_fwd(ex_rs2, mem_rd, mem_reg_write, lt_q_rd, lt_q_valid,
                           wb_rd, wb_reg_write);
    end
  end

  assign load_use = ex_mem_read && ex_reg_write && (ex_rd != '0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));
  assign raw      = (id_use_rs1 && blocked(id_rs1, sb_busy, lt_done, lt_rd)) ||
                    (id_use_rs2 && blocked(id_rs2, sb_busy, lt_done, lt_rd));
  assign waw      = id_reg_write && blocked(id_rd, sb_busy, lt_done, lt_rd);
  assign stall_id = !rst && !flush && (load_use || raw || waw);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      lt_q_valid  <= 1'b0;
      lt_q_rd     <= '0;
      stall_count <= '0;
    end else begin
      lt_q_valid <= lt_done && (lt_rd != '0);
      lt_q_rd    <= lt_rd;
      if (stall_id && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// long randomized run, all compared every cycle against a behavioural model.
module tb_hazard_forward_unit;

  localparam int NR = 32;
  localparam int AW = 5;
  localparam int LW = 4;
  localparam int CW = 4;
  localparam int SC_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] id_rs1, id_rs2, id_rd, ex_rs1, ex_rs2, ex_rd;
  logic [AW-1:0] mem_rd, wb_rd, lt_rd;
  logic          id_use_rs1, id_use_rs2, id_reg_write;
  logic          ex_reg_write, ex_mem_read, ex_long_issue;
  logic [LW-1:0] ex_long_lat;
  logic          mem_reg_write, wb_reg_write, lt_done, flush;
  logic [1:0]    forward_a, forward_b;
  logic          stall_id, sb_timeout;
  logic [NR-1:0] sb_busy;
  logic [CW-1:0] stall_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  bit m_pend [NR];
  int m_cnt  [NR];
  bit m_ltv;
  int m_ltrd;
  bit m_to;
  int m_sc;

  always #5 clk = ~clk;

  hazard_forward_unit #(.NUM_REGS(NR), .REG_AW(AW), .LAT_W(LW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_long_issue(ex_long_issue), .ex_long_lat(ex_long_lat),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .lt_done(lt_done), .lt_rd(lt_rd), .flush(flush),
    .forward_a(forward_a), .forward_b(forward_b), .stall_id(stall_id),
    .sb_busy(sb_busy), .sb_timeout(sb_timeout), .stall_count(stall_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit blk(int s);
    return (s != 0) && m_pend[s] && !(lt_done && (int'(lt_rd) == s));
  endfunction

  function automatic int exp_fwd(int s);
    if (rst || s == 0)                          return 0;
    if (mem_reg_write && int'(mem_rd) == s)     return 2;
    if (m_ltv && m_ltrd == s)                   return 3;
    if (wb_reg_write && int'(wb_rd) == s)       return 1;
    return 0;
  endfunction

  function automatic bit exp_stall();
    bit lu, rw, ww;
    if (rst || flush) return 0;
    lu = ex_mem_read && ex_reg_write && ex_rd != 0 &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    rw = (id_use_rs1 && blk(int'(id_rs1))) || (id_use_rs2 && blk(int'(id_rs2)));
    ww = id_reg_write && blk(int'(id_rd));
    return lu || rw || ww;
  endfunction

  task automatic compare();
    logic [NR-1:0] busy;
    for (int r = 0; r < NR; r++) busy[r] = m_pend[r];
    check("forward_a",   64'(forward_a),   64'(exp_fwd(int'(ex_rs1))));
    check("forward_b",   64'(forward_b),   64'(exp_fwd(int'(ex_rs2))));
    check("stall_id",    64'(stall_id),    64'(exp_stall()));
    check("sb_busy",     64'(sb_busy),     64'(busy));
    check("sb_timeout",  64'(sb_timeout),  64'(m_to));
    check("stall_count", 64'(stall_count), 64'(m_sc));
  endtask

  task automatic model_edge();
    bit st;
    st = exp_stall();
    if (rst) begin
      for (int r = 0; r < NR; r++) begin m_pend[r] = 0; m_cnt[r] = 0; end
      m_ltv = 0; m_to = 0; m_sc = 0;
    end else begin
      if (st && m_sc < SC_MAX) m_sc++;
      for (int r = 0; r < NR; r++) begin
        bit clr, set;
        clr = lt_done && int'(lt_rd) == r;
        set = ex_long_issue && ex_reg_write && ex_rd != 0 && int'(ex_rd) == r;
        if (m_pend[r] && m_cnt[r] == 0 && !clr) m_to = 1;
        if (set) begin m_pend[r] = 1; m_cnt[r] = (ex_long_lat == 0) ? 1 : int'(ex_long_lat); end
        else if (clr) begin m_pend[r] = 0; m_cnt[r] = 0; end
        else if (m_pend[r] && m_cnt[r] > 0) m_cnt[r]--;
      end
      m_ltv  = lt_done && lt_rd != 0;
      m_ltrd = int'(lt_rd);
    end
  endtask

  task automatic idle();
    rst = 0; flush = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_reg_write = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0;
    ex_long_issue = 0; ex_long_lat = 0;
    mem_rd = 0; mem_reg_write = 0; wb_rd = 0; wb_reg_write = 0; lt_done = 0; lt_rd = 0;
  endtask

  // Inputs are set at the negedge; settle, compare, then advance one edge.
  task automatic settle(); #1; compare(); endtask
  task automatic tick(); @(posedge clk); model_edge(); @(negedge clk); endtask

  task automatic issue(input int rd, input int lat);
    ex_long_issue = 1; ex_reg_write = 1; ex_rd = AW'(rd); ex_long_lat = LW'(lat);
  endtask

  initial begin
    idle(); rst = 1;
    @(negedge clk); settle(); tick();
    settle(); tick();
    idle(); settle();
    check("reset_busy", 64'(sb_busy), 64'd0);
    check("reset_sc", 64'(stall_count), 64'd0);
    check("reset_to", 64'(sb_timeout), 64'd0);
    tick();

    // Forward priority
    idle(); ex_rs1 = 5; mem_rd = 5; mem_reg_write = 1; wb_rd = 5; wb_reg_write = 1;
    settle(); check("fwd_mem_over_wb", 64'(forward_a), 64'b10); tick();
    mem_reg_write = 0; settle(); check("fwd_wb", 64'(forward_a), 64'b01); tick();
    idle(); mem_reg_write = 1; wb_reg_write = 1; lt_done = 0;
    settle(); check("fwd_r0", 64'(forward_a), 64'b00); tick();

    // Load-use
    idle(); ex_mem_read = 1; ex_reg_write = 1; ex_rd = 7; id_use_rs2 = 1; id_rs2 = 7;
    settle(); check("lu_stall", 64'(stall_id), 64'd1); check("lu_sc0", 64'(stall_count), 64'd0); tick();
    idle(); mem_rd = 7; mem_reg_write = 1; ex_rs2 = 7;
    settle(); check("lu_fwd_b", 64'(forward_b), 64'b10); check("lu_sc1", 64'(stall_count), 64'd1);
    check("lu_release", 64'(stall_id), 64'd0); tick();

    // Long RAW with lt_q bypass
    idle(); issue(9, 6); settle(); tick();
    for (int c = 1; c <= 3; c++) begin
      idle(); id_use_rs1 = 1; id_rs1 = 9; settle();
      check("raw_stall", 64'(stall_id), 64'd1); check("raw_busy9", 64'(sb_busy[9]), 64'd1); tick();
    end
    idle(); id_use_rs1 = 1; id_rs1 = 9; lt_done = 1; lt_rd = 9;
    settle(); check("raw_release", 64'(stall_id), 64'd0); tick();
    idle(); ex_rs1 = 9; settle();
    check("raw_fwd_lt", 64'(forward_a), 64'b11); check("raw_busy9_clr", 64'(sb_busy[9]), 64'd0); tick();

    // WAW and set-wins
    idle(); issue(9, 6); settle(); tick();
    idle(); id_reg_write = 1; id_rd = 9; settle(); check("waw_stall", 64'(stall_id), 64'd1); tick();
    idle(); issue(3, 5); settle(); tick();
    idle(); issue(3, 5); lt_done = 1; lt_rd = 3; settle(); tick();
    idle(); settle(); check("set_wins", 64'(sb_busy[3]), 64'd1); tick();
    idle(); lt_done = 1; lt_rd = 3; settle(); tick();
    idle(); lt_done = 1; lt_rd = 9; settle(); tick();
    idle(); settle(); check("sb_drained", 64'(sb_busy), 64'd0); tick();

    // Watchdog
    idle(); issue(4, 2); settle(); tick();
    idle(); settle(); tick();
    idle(); settle(); tick();
    idle(); settle(); check("wd_not_yet", 64'(sb_timeout), 64'd0); tick();
    idle(); settle(); check("wd_fired", 64'(sb_timeout), 64'd1); tick();
    idle(); settle(); tick();
    idle(); lt_done = 1; lt_rd = 4; settle(); tick();
    idle(); settle(); check("wd_busy4_clr", 64'(sb_busy[4]), 64'd0);
    check("wd_sticky", 64'(sb_timeout), 64'd1); tick();

    // Flush, then reset mid-op
    idle(); issue(6, 8); settle(); tick();
    idle(); id_use_rs2 = 1; id_rs2 = 6; settle(); check("fl_pre", 64'(stall_id), 64'd1); tick();
    flush = 1; settle(); check("fl_stall0", 64'(stall_id), 64'd0); check("fl_busy6", 64'(sb_busy[6]), 64'd1); tick();
    flush = 0; settle(); check("fl_busy6_kept", 64'(sb_busy[6]), 64'd1);
    rst = 1; ex_rs1 = 5; mem_rd = 5; mem_reg_write = 1; settle();
    check("rst_stall0", 64'(stall_id), 64'd0); check("rst_fwd0", 64'(forward_a), 64'd0); tick();
    idle(); settle();
    check("rst_busy", 64'(sb_busy), 64'd0); check("rst_sc", 64'(stall_count), 64'd0);
    check("rst_to", 64'(sb_timeout), 64'd0); tick();

    // Stall counter saturation
    for (int c = 0; c < 20; c++) begin
      idle(); ex_mem_read = 1; ex_reg_write = 1; ex_rd = 2; id_use_rs1 = 1; id_rs1 = 2;
      settle(); tick();
    end
    idle(); settle(); check("sc_saturate", 64'(stall_count), 64'(SC_MAX)); tick();

    // Randomized run
    for (int c = 0; c < 4000; c++) begin
      rst           = ($urandom_range(0, 149) == 0);
      flush         = ($urandom_range(0, 7) == 0);
      id_rs1        = AW'($urandom_range(0, 7));
      id_rs2        = AW'($urandom_range(0, 7));
      id_rd         = AW'($urandom_range(0, 7));
      id_use_rs1    = 1'($urandom_range(0, 1));
      id_use_rs2    = 1'($urandom_range(0, 1));
      id_reg_write  = 1'($urandom_range(0, 1));
      ex_rs1        = AW'($urandom_range(0, 7));
      ex_rs2        = AW'($urandom_range(0, 7));
      ex_rd         = AW'($urandom_range(0, 7));
      ex_reg_write  = 1'($urandom_range(0, 1));
      ex_mem_read   = ($urandom_range(0, 3) == 0);
      ex_long_issue = ($urandom_range(0, 4) == 0);
      ex_long_lat   = LW'($urandom_range(0, 6));
      mem_rd        = AW'($urandom_range(0, 7));
      mem_reg_write = 1'($urandom_range(0, 1));
      wb_rd         = AW'($urandom_range(0, 7));
      wb_reg_write  = 1'($urandom_range(0, 1));
      lt_done       = ($urandom_range(0, 2) == 0);
      lt_rd         = AW'($urandom_range(0, 7));
      settle(); tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
